dma_bench_engine: RTL and testbench

- Receiving end of the DMA benchmark command stream produced by the AXI-lite benchmark register block.
- Accepts one 193-bit benchmark command and expands it into a sequence of chunked DMA read or write requests with strided, wrapping addresses.
- Tracks completions and a bounded number of outstanding requests.
- Reports execution cycles on a 64-bit output that the register block reads back over AXI-lite.

---
 rtl/dma_bench_engine.sv | 153 +++++++++++++++
 tb/tb_dma_bench_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bench_engine.sv
// Turns one benchmark command into a run of chunked DMA requests with strided, wrapping addresses.
// It counts completions, limits the number of outstanding requests and measures the run length in cycles.
module dma_bench_engine #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CYCLE_WIDTH     = 64
) (
    input  logic                   user_clk,
    input  logic                   user_areset,
    input  logic                   s_axis_cmd_valid,
    output logic                   s_axis_cmd_ready,
    input  logic [192:0]           s_axis_cmd_data,
    output logic                   m_axis_dma_cmd_valid,
    input  logic                   m_axis_dma_cmd_ready,
    output logic [63:0]            m_axis_dma_cmd_addr,
    output logic [31:0]            m_axis_dma_cmd_len,
    output logic                   m_axis_dma_cmd_write,
    input  logic                   s_axis_dma_sts_valid,
    output logic                   s_axis_dma_sts_ready,
    output logic [CYCLE_WIDTH-1:0] execution_cycles,
    output logic                   busy,
    output logic                   done
);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic                   live_q;
    logic [47:0]            base_q, base_d, size_q, size_d;
    logic [31:0]            n_q, n_d, chunk_q, chunk_d, stride_q, stride_d;
    logic                   wr_q, wr_d;
    logic [48:0]            offset_q, offset_d;
    logic [31:0]            issued_q, issued_d, completed_q, completed_d;
    logic [OW-1:0]          outst_q, outst_d;
    logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;

    logic        cmd_hs, req_hs, sts_ok, running;
    logic [48:0] next_off;

    assign running              = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    // live_q keeps both ready outputs low until the first edge after reset release.
    assign s_axis_cmd_ready     = live_q && (state_q == S_IDLE);
    assign s_axis_dma_sts_ready = live_q;
    assign m_axis_dma_cmd_valid = (state_q == S_ISSUE) && (issued_q < n_q) &&
                                  (outst_q < OW'(MAX_OUTSTANDING));
    assign m_axis_dma_cmd_addr  = {16'h0, base_q + offset_q[47:0]};
    assign m_axis_dma_cmd_len   = chunk_q;
    assign m_axis_dma_cmd_write = wr_q;
    assign execution_cycles     = cycles_q;
    assign busy                 = running;
    assign done                 = (state_q == S_DONE);

    assign cmd_hs = s_axis_cmd_valid && s_axis_cmd_ready;
    assign req_hs = m_axis_dma_cmd_valid && m_axis_dma_cmd_ready;
    assign sts_ok = s_axis_dma_sts_valid && live_q && running && (outst_q != '0);

    always_comb begin
        next_off = {1'b0, offset_q[47:0]} + {17'h0, stride_q};
        if (next_off + {17'h0, chunk_q} > {1'b0, size_q})
            next_off = '0;
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        size_d      = size_q;
        n_d         = n_q;
        chunk_d     = chunk_q;
        stride_d    = stride_q;
        wr_d        = wr_q;
        offset_d    = offset_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        outst_d     = outst_q;
        cycles_d    = cycles_q;

        if (running) begin
            if (req_hs) begin
                issued_d = issued_q + 32'd1;
                offset_d = next_off;
            end
            completed_d = completed_q + {31'h0, sts_ok};
            outst_d     = outst_q + OW'(req_hs) - OW'(sts_ok);
            if (cycles_q != '1)
                cycles_d = cycles_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    base_d      = s_axis_cmd_data[47:0];
                    size_d      = s_axis_cmd_data[95:48];
                    n_d         = s_axis_cmd_data[127:96];
                    chunk_d     = s_axis_cmd_data[159:128];
                    stride_d    = s_axis_cmd_data[191:160];
                    wr_d        = s_axis_cmd_data[192];
                    offset_d    = '0;
                    issued_d    = '0;
                    completed_d = '0;
                    outst_d     = '0;
                    cycles_d    = '0;
                    if (s_axis_cmd_data[127:96] == 32'd0 || s_axis_cmd_data[159:128] == 32'd0)
                        state_d = S_DONE;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_hs && (issued_d == n_q))
                    state_d = S_DRAIN;
            end
            // Leave on the edge that takes the final completion.
            S_DRAIN: begin
                if (completed_d == n_q)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_areset) begin
        if (user_areset) begin
            state_q     <= S_IDLE;
            live_q      <= 1'b0;
            base_q      <= '0;
            size_q      <= '0;
            n_q         <= '0;
            chunk_q     <= '0;
            stride_q    <= '0;
            wr_q        <= 1'b0;
            offset_q    <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            outst_q     <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= 1'b1;
            base_q      <= base_d;
            size_q      <= size_d;
            n_q         <= n_d;
            chunk_q     <= chunk_d;
            stride_q    <= stride_d;
            wr_q        <= wr_d;
            offset_q    <= offset_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            outst_q     <= outst_d;
            cycles_q    <= cycles_d;
        end
    end
endmodule

// File: tb/tb_dma_bench_engine.sv
// Directed bench for dma_bench_engine: hand-computed addresses, handshake counts and cycle totals.
module tb_dma_bench_engine;
    logic         user_clk = 1'b0;
    logic         user_areset = 1'b1;
    logic         s_axis_cmd_valid = 1'b0;
    logic         s_axis_cmd_ready;
    logic [192:0] s_axis_cmd_data = '0;
    logic         m_axis_dma_cmd_valid;
    logic         m_axis_dma_cmd_ready = 1'b0;
    logic [63:0]  m_axis_dma_cmd_addr;
    logic [31:0]  m_axis_dma_cmd_len;
    logic         m_axis_dma_cmd_write;
    logic         s_axis_dma_sts_valid = 1'b0;
    logic         s_axis_dma_sts_ready;
    logic [63:0]  execution_cycles;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    int hs     = 0;

    dma_bench_engine #(.MAX_OUTSTANDING(8), .CYCLE_WIDTH(64)) dut (
        .user_clk             (user_clk),
        .user_areset          (user_areset),
        .s_axis_cmd_valid     (s_axis_cmd_valid),
        .s_axis_cmd_ready     (s_axis_cmd_ready),
        .s_axis_cmd_data      (s_axis_cmd_data),
        .m_axis_dma_cmd_valid (m_axis_dma_cmd_valid),
        .m_axis_dma_cmd_ready (m_axis_dma_cmd_ready),
        .m_axis_dma_cmd_addr  (m_axis_dma_cmd_addr),
        .m_axis_dma_cmd_len   (m_axis_dma_cmd_len),
        .m_axis_dma_cmd_write (m_axis_dma_cmd_write),
        .s_axis_dma_sts_valid (s_axis_dma_sts_valid),
        .s_axis_dma_sts_ready (s_axis_dma_sts_ready),
        .execution_cycles     (execution_cycles),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic step_cnt();
        if (m_axis_dma_cmd_valid === 1'b1 && m_axis_dma_cmd_ready === 1'b1) hs++;
        step();
    endtask

    function automatic logic [192:0] mkcmd(input logic [47:0] base, input logic [47:0] size,
                                           input logic [31:0] n, input logic [31:0] chunk,
                                           input logic [31:0] stride, input logic wr);
        return {wr, stride, chunk, n, size, base};
    endfunction

    task automatic send(input logic [192:0] c);
        s_axis_cmd_data  = c;
        s_axis_cmd_valid = 1'b1;
        chk("accept_ready", s_axis_cmd_ready, 1);
        step();
        s_axis_cmd_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, s_axis_cmd_ready, 0);
        chk({tag, "_valid"}, m_axis_dma_cmd_valid, 0);
        chk({tag, "_addr"}, m_axis_dma_cmd_addr, 0);
        chk({tag, "_len"}, m_axis_dma_cmd_len, 0);
        chk({tag, "_write"}, m_axis_dma_cmd_write, 0);
        chk({tag, "_sts_ready"}, s_axis_dma_sts_ready, 0);
        chk({tag, "_cycles"}, execution_cycles, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    logic [63:0] exp1 [4];
    logic [63:0] exp2 [5];

    initial begin
        exp1 = '{64'h1000, 64'h1080, 64'h1100, 64'h1180};
        exp2 = '{64'h0, 64'h100, 64'h0, 64'h100, 64'h0};

        // reset state and release
        #1;
        check_all_zero("rst");
        step();
        user_areset = 1'b0;
        #1;
        chk("rel_ready_low", s_axis_cmd_ready, 0);
        step();
        chk("rel_ready_high", s_axis_cmd_ready, 1);
        chk("rel_sts_ready", s_axis_dma_sts_ready, 1);

        // 1: basic write run, completions two edges after each request
        m_axis_dma_cmd_ready = 1'b1;
        send(mkcmd(48'h1000, 48'h10000, 4, 64, 128, 1'b1));
        chk("t1_busy", busy, 1);
        chk("t1_len", m_axis_dma_cmd_len, 64);
        chk("t1_write", m_axis_dma_cmd_write, 1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", m_axis_dma_cmd_valid, 1);
            chk("t1_addr", m_axis_dma_cmd_addr, exp1[k]);
            if (k >= 2) s_axis_dma_sts_valid = 1'b1;
            step();
        end
        chk("t1_drain_valid", m_axis_dma_cmd_valid, 0);
        chk("t1_drain_busy", busy, 1);
        step();
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 0);
        chk("t1_cycles", execution_cycles, 6);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_cycles_hold", execution_cycles, 6);
        chk("t1_idle_ready", s_axis_cmd_ready, 1);

        // 2: wrap-around read
        send(mkcmd(48'h0, 48'h200, 5, 32'h100, 32'h100, 1'b0));
        chk("t2_write", m_axis_dma_cmd_write, 0);
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", m_axis_dma_cmd_valid, 1);
            chk("t2_addr", m_axis_dma_cmd_addr, exp2[k]);
            step();
        end
        s_axis_dma_sts_valid = 1'b1;
        repeat (4) step();
        chk("t2_not_done", done, 0);
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_cycles", execution_cycles, 10);
        step();

        // 3: outstanding limit of 8 with 12 accesses
        send(mkcmd(48'h4000, 48'h10000, 12, 16, 16, 1'b0));
        hs = 0;
        repeat (12) step_cnt();
        chk("t3_hs_limit", hs, 8);
        chk("t3_valid_low", m_axis_dma_cmd_valid, 0);
        s_axis_dma_sts_valid = 1'b1;
        repeat (4) step_cnt();
        s_axis_dma_sts_valid = 1'b0;
        repeat (6) step_cnt();
        chk("t3_hs_total", hs, 12);
        chk("t3_valid_end", m_axis_dma_cmd_valid, 0);
        chk("t3_busy", busy, 1);
        chk("t3_not_done_4", done, 0);
        s_axis_dma_sts_valid = 1'b1;
        repeat (7) step();
        chk("t3_not_done_11", done, 0);
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t3_done", done, 1);
        step();

        // 4: zero accesses, then a spurious completion in IDLE
        send(mkcmd(48'h0, 48'h1000, 0, 64, 64, 1'b1));
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_valid", m_axis_dma_cmd_valid, 0);
        chk("t4_cycles", execution_cycles, 0);
        chk("t4_ready_low", s_axis_cmd_ready, 0);
        step();
        chk("t4_done_pulse", done, 0);
        chk("t4_ready", s_axis_cmd_ready, 1);
        s_axis_dma_sts_valid = 1'b1;
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t4_spur_cycles", execution_cycles, 0);
        chk("t4_spur_busy", busy, 0);

        // 5: request/completion collision, then reset in DRAIN
        send(mkcmd(48'h0, 48'h100000, 10, 8, 8, 1'b0));
        hs = 0;
        repeat (7) step_cnt();
        chk("t5_hs7", hs, 7);
        chk("t5_valid_pre", m_axis_dma_cmd_valid, 1);
        s_axis_dma_sts_valid = 1'b1;
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t5_coll_valid", m_axis_dma_cmd_valid, 1);
        chk("t5_coll_addr", m_axis_dma_cmd_addr, 64'h40);
        step();
        chk("t5_full", m_axis_dma_cmd_valid, 0);
        s_axis_dma_sts_valid = 1'b1;
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t5_reopen", m_axis_dma_cmd_valid, 1);
        step();
        chk("t5_drain_busy", busy, 1);
        chk("t5_drain_valid", m_axis_dma_cmd_valid, 0);
        #2;
        user_areset = 1'b1;
        #1;
        check_all_zero("t5_rst");
        step();
        user_areset = 1'b0;
        #1;
        chk("t5_rel_ready_low", s_axis_cmd_ready, 0);
        step();
        chk("t5_rel_ready", s_axis_cmd_ready, 1);
        s_axis_dma_sts_valid = 1'b1;
        step();
        s_axis_dma_sts_valid = 1'b0;
        send(mkcmd(48'h3000, 48'h1000, 1, 4, 4, 1'b0));
        chk("t5_post_valid", m_axis_dma_cmd_valid, 1);
        chk("t5_post_addr", m_axis_dma_cmd_addr, 64'h3000);
        step();
        s_axis_dma_sts_valid = 1'b1;
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t5_post_done", done, 1);
        chk("t5_post_cycles", execution_cycles, 2);
        step();

        // 6: second command waits; spurious completion at outstanding 0 is ignored
        m_axis_dma_cmd_ready = 1'b1;
        send(mkcmd(48'h2000, 48'h10000, 2, 32, 32, 1'b1));
        m_axis_dma_cmd_ready = 1'b0;
        s_axis_dma_sts_valid = 1'b1;
        s_axis_cmd_data  = mkcmd(48'h0, 48'h100, 0, 8, 8, 1'b0);
        s_axis_cmd_valid = 1'b1;
        chk("t6_ready_issue", s_axis_cmd_ready, 0);
        step();
        m_axis_dma_cmd_ready = 1'b1;
        s_axis_dma_sts_valid = 1'b0;
        chk("t6_addr0", m_axis_dma_cmd_addr, 64'h2000);
        chk("t6_ready_issue2", s_axis_cmd_ready, 0);
        step();
        chk("t6_addr1", m_axis_dma_cmd_addr, 64'h2020);
        step();
        chk("t6_drain_busy", busy, 1);
        chk("t6_ready_drain", s_axis_cmd_ready, 0);
        s_axis_dma_sts_valid = 1'b1;
        step();
        chk("t6_not_done", done, 0);
        step();
        s_axis_dma_sts_valid = 1'b0;
        chk("t6_done", done, 1);
        chk("t6_cycles", execution_cycles, 5);
        chk("t6_ready_done", s_axis_cmd_ready, 0);
        step();
        chk("t6_ready_after", s_axis_cmd_ready, 1);
        chk("t6_cycles_hold", execution_cycles, 5);
        step();
        s_axis_cmd_valid = 1'b0;
        chk("t6_second_done", done, 1);
        chk("t6_cycles_clear", execution_cycles, 0);
        step();
        chk("t6_idle", s_axis_cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
